// File: rtl/sipo_rx_pkg.sv
// ============================================================================
// Module   : sipo_rx_pkg
// Brief    : Shared state encodings and line-level constants for the SIPO link.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package sipo_rx_pkg;

    // Encodings are shared with the transmitter side of the link.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam logic C_LINE_IDLE = 1'b1;
    localparam logic C_START_BIT = 1'b0;
    localparam logic C_STOP_BIT  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sipo_shift.sv
// ============================================================================
// Module   : sipo_shift
// Brief    : WIDTH-bit enabled shift register; direction chosen by MSB_FIRST.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sipo_shift #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;

    // MSB-first enters at bit 0 and walks up, so the first bit ends in the MSB.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_q_next = {r_q[WIDTH-2:0], d_i};
        end else begin : g_lsb_first
            assign w_q_next = {d_i, r_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_q <= '0;
        end else if (en_i) begin
            r_q <= w_q_next;
        end
    end

    assign q_o = r_q;

endmodule

`default_nettype wire

// File: rtl/sipo_rx.sv
// ============================================================================
// Module   : sipo_rx
// Brief    : Framed serial-to-parallel receiver with one-deep valid/ready buffer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sipo_rx
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ser_i,
    input  logic             ser_en_i,
    output logic [WIDTH-1:0] par_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             frame_err_o,
    output logic             overrun_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_next;
    logic             w_shift_en;
    logic             w_good;
    logic             w_bad;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] r_par;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_overrun;

    sipo_shift #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (w_shift_en),
        .d_i   (ser_i),
        .q_o   (w_word)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_en     = 1'b0;
        w_good         = 1'b0;
        w_bad          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ser_en_i && (ser_i == C_START_BIT)) begin
                    w_state_next   = ST_DATA;
                    w_bit_cnt_next = '0;
                end
            end
            ST_DATA: begin
                if (ser_en_i) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == C_LAST_BIT) begin
                        w_state_next   = ST_STOP;
                        w_bit_cnt_next = '0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (ser_en_i) begin
                    w_state_next = ST_IDLE;
                    w_good       = (ser_i == C_STOP_BIT);
                    w_bad        = (ser_i != C_STOP_BIT);
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // A consume on the same edge as a new word frees the slot, so no overrun.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_par       <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_bad;
            r_overrun   <= w_good && r_valid && !ready_i;
            if (w_good && (!r_valid || ready_i)) begin
                r_par   <= w_word;
                r_valid <= 1'b1;
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign par_o       = r_par;
    assign valid_o     = r_valid;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_sipo_rx.sv
// ============================================================================
// Module   : tb_sipo_rx
// Brief    : Directed bench for sipo_rx; MSB-first and LSB-first instances share stimulus.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sipo_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ser = 1'b1;
    logic       ser_en = 1'b0;
    logic       ready = 1'b0;
    logic [3:0] par_m, par_l;
    logic       valid_m, valid_l;
    logic       ferr_m, ferr_l;
    logic       ovr_m, ovr_l;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ser_i       (ser),
        .ser_en_i    (ser_en),
        .par_o       (par_m),
        .valid_o     (valid_m),
        .ready_i     (ready),
        .frame_err_o (ferr_m),
        .overrun_o   (ovr_m)
    );

    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk_i       (clk),
        .rst_i       (rst),
        .ser_i       (ser),
        .ser_en_i    (ser_en),
        .par_o       (par_l),
        .valid_o     (valid_l),
        .ready_i     (ready),
        .frame_err_o (ferr_l),
        .overrun_o   (ovr_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobed bit followed by 'gap' unstrobed cycles carrying the inverted level.
    task automatic send_bit(input logic b, input int gap);
        ser    = b;
        ser_en = 1'b1;
        tick();
        ser_en = 1'b0;
        ser    = ~b;
        repeat (gap) tick();
        ser    = 1'b1;
    endtask

    task automatic send_frame(input logic [5:0] bits, input int gap);
        for (int i = 5; i >= 0; i--) send_bit(bits[i], gap);
    endtask

    task automatic consume();
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        check("reset_par",   par_m,   4'h0);
        check("reset_valid", valid_m, 1'b0);
        check("reset_ferr",  ferr_m,  1'b0);
        check("reset_ovr",   ovr_m,   1'b0);
        rst = 1'b0;
        tick();

        // Basic frame: data 1,0,1,0
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        check("basic_valid_before_stop", valid_m, 1'b0);
        send_bit(1'b1, 0);
        check("basic_par_msb",  par_m,   4'b1010);
        check("basic_valid",    valid_m, 1'b1);
        check("basic_ferr",     ferr_m,  1'b0);
        check("basic_ovr",      ovr_m,   1'b0);
        check("basic_par_lsb",  par_l,   4'b0101);
        check("basic_valid_lsb", valid_l, 1'b1);
        tick();
        check("basic_valid_hold", valid_m, 1'b1);
        consume();
        check("consume_valid",   valid_m, 1'b0);
        check("consume_par_kept", par_m,  4'b1010);
        ready = 1'b1;
        tick();
        check("ready_no_effect_idle", valid_m, 1'b0);
        ready = 1'b0;

        // Stop bit sent as 0
        send_frame(6'b011110, 0);
        check("ferr_pulse",      ferr_m,  1'b1);
        check("ferr_valid_low",  valid_m, 1'b0);
        check("ferr_par_kept",   par_m,   4'b1010);
        tick();
        check("ferr_pulse_end",  ferr_m,  1'b0);
        send_frame(6'b000111, 0);
        check("after_ferr_par",  par_m,   4'b0011);
        check("after_ferr_valid", valid_m, 1'b1);
        check("after_ferr_noerr", ferr_m, 1'b0);
        consume();

        // Overrun: A then 5 with ready low
        send_frame(6'b010101, 0);
        check("ovr_first_par", par_m, 4'hA);
        send_frame(6'b001011, 0);
        check("ovr_pulse",      ovr_m,   1'b1);
        check("ovr_par_kept",   par_m,   4'hA);
        check("ovr_valid",      valid_m, 1'b1);
        check("ovr_lsb_pulse",  ovr_l,   1'b1);
        tick();
        check("ovr_pulse_end",  ovr_m,   1'b0);

        // Same second frame, consumer ready on the stop edge
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        ready = 1'b1;
        send_bit(1'b1, 0);
        ready = 1'b0;
        check("simul_par",   par_m,   4'h5);
        check("simul_valid", valid_m, 1'b1);
        check("simul_ovr",   ovr_m,   1'b0);
        consume();

        // Strobe every third cycle, frame C
        send_bit(1'b0, 2);
        send_bit(1'b1, 2);
        send_bit(1'b1, 2);
        send_bit(1'b0, 2);
        send_bit(1'b0, 2);
        check("slow_valid_before_stop", valid_m, 1'b0);
        send_bit(1'b1, 0);
        check("slow_par",   par_m,   4'hC);
        check("slow_valid", valid_m, 1'b1);
        check("slow_lsb",   par_l,   4'h3);
        consume();

        // Back-to-back frames with ready held high
        ready = 1'b1;
        send_frame(6'b010101, 0);
        check("b2b_first_par", par_m, 4'hA);
        send_frame(6'b001011, 0);
        check("b2b_second_par", par_m, 4'h5);
        check("b2b_no_ovr",     ovr_m, 1'b0);
        tick();
        check("b2b_drained", valid_m, 1'b0);
        ready = 1'b0;

        // Reset in the middle of a frame, with a word pending
        send_frame(6'b000111, 0);
        check("prerst_valid", valid_m, 1'b1);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        rst = 1'b1;
        #1;
        check("rst_par_async",   par_m,   4'h0);
        check("rst_valid_async", valid_m, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        send_frame(6'b010011, 0);
        check("postrst_par",   par_m,   4'h9);
        check("postrst_valid", valid_m, 1'b1);
        check("postrst_ferr",  ferr_m,  1'b0);
        check("postrst_lsb",   par_l,   4'h9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
